// File: rtl/alu_share_arb.sv
// Two-requester arbiter that time-shares one combinational ALU and buffers one tagged result.
// Optional macro ALU_ARB_RR_EN selects round-robin contention; default build is fixed priority (requester 0 wins).
module alu_share_arb #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WORD_LEN-1:0] req0_a,
  input  logic [WORD_LEN-1:0] req0_b,
  input  logic [3:0]          req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WORD_LEN-1:0] req1_a,
  input  logic [WORD_LEN-1:0] req1_b,
  input  logic [3:0]          req1_op,
  output logic [WORD_LEN-1:0] alu_a,
  output logic [WORD_LEN-1:0] alu_b,
  output logic [3:0]          alu_op,
  input  logic [WORD_LEN-1:0] alu_out,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                alu_ge,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WORD_LEN-1:0] rsp_data,
  output logic [2:0]          rsp_flags
);

  logic grantValid;
  logic grantId;
  logic readyEn;
  logic canAccept;
  logic accept;

  assign grantValid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
  logic lastId;

  always_comb begin
    grantId = ~req0_valid;
    if (req0_valid && req1_valid) grantId = ~lastId;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastId <= 1'b1;
    end else if (accept) begin
      lastId <= grantId;
    end
  end
`else
  assign grantId = ~req0_valid;
`endif

  // readyEn keeps both readies low from reset assertion until the first edge after release.
  assign canAccept  = readyEn && (!rsp_valid || rsp_ready);
  assign req0_ready = canAccept && grantValid && !grantId;
  assign req1_ready = canAccept && grantValid && grantId;
  assign accept     = req0_ready | req1_ready;

  // Grant does not depend on rsp_ready, so the ALU inputs have no path from it.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 4'b0000;
    if (grantValid) begin
      if (grantId) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyEn   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= 3'b000;
    end else begin
      readyEn <= 1'b1;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grantId;
        rsp_data  <= alu_out;
        rsp_flags <= {alu_zero, alu_lt, alu_ge};
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU; expectations follow ALU_ARB_RR_EN.
module tb_alu_share_arb;

  localparam int W = 32;
  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
`ifdef ALU_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic alu_zero, alu_lt, alu_ge;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;
  logic [2:0] rsp_flags;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WORD_LEN(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ge(alu_ge),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  // Behavioural ALU: flags compare the operands as signed values.
  always_comb begin
    case (alu_op)
      OpAdd:   alu_out = alu_a + alu_b;
      OpSub:   alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
    alu_lt   = ($signed(alu_a) < $signed(alu_b));
    alu_ge   = !alu_lt;
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready)
      $display("rsp  id=%0d data=%h flags=%b", rsp_id, rsp_data, rsp_flags);
  end

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic test_reset;
    rst = 1'b1; rsp_ready = 1'b0;
    drive0(1'b1, 32'd1, 32'd1, OpAdd);
    drive1(1'b0, '0, '0, OpAdd);
    #3;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id); end
    checks++; if (rsp_data !== 32'd0) begin fails++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    checks++; if (rsp_flags !== 3'b000) begin fails++; $display("FAIL reset_rsp_flags got=%b want=000", rsp_flags); end
    checks++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_req0_ready got=%b want=0", req0_ready); end
    drive0(1'b0, '0, '0, OpAdd);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_single;
    @(negedge clk);
    drive0(1'b1, 32'd5, 32'd3, OpAdd); rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL single_req0_ready got=%b want=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL single_req1_ready got=%b want=0", req1_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_rsp_valid got=%b want=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL single_rsp_id got=%b want=0", rsp_id); end
    checks++; if (rsp_data !== 32'd8) begin fails++; $display("FAIL single_rsp_data got=%h want=8", rsp_data); end
    checks++; if (rsp_flags !== 3'b001) begin fails++; $display("FAIL single_rsp_flags got=%b want=001", rsp_flags); end
    @(negedge clk); drive0(1'b0, '0, '0, OpAdd);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain got=%b want=0", rsp_valid); end
  endtask

  task automatic test_negative;
    @(negedge clk);
    drive1(1'b1, 32'd2, 32'd5, OpSub); rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL neg_req1_ready got=%b want=1", req1_ready); end
    checks++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL neg_req0_ready got=%b want=0", req0_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_data !== 32'hFFFF_FFFD) begin fails++; $display("FAIL neg_rsp_data got=%h want=fffffffd", rsp_data); end
    checks++; if (rsp_flags !== 3'b010) begin fails++; $display("FAIL neg_rsp_flags got=%b want=010", rsp_flags); end
    checks++; if (rsp_id !== 1'b1) begin fails++; $display("FAIL neg_rsp_id got=%b want=1", rsp_id); end
    @(negedge clk); drive1(1'b0, '0, '0, OpAdd);
  endtask

  task automatic test_contention;
    logic expId;
    logic [W-1:0] expData;
    @(negedge clk);
    drive0(1'b1, 32'd10, 32'd0, OpAdd);
    drive1(1'b1, 32'd20, 32'd0, OpAdd);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expId = RrEn ? i[0] : 1'b0;
      expData = expId ? 32'd20 : 32'd10;
      if (i != 0) @(negedge clk);
      #1;
      checks++; if (req0_ready !== !expId) begin fails++; $display("FAIL cont_req0_ready[%0d] got=%b want=%b", i, req0_ready, !expId); end
      checks++; if (req1_ready !== expId) begin fails++; $display("FAIL cont_req1_ready[%0d] got=%b want=%b", i, req1_ready, expId); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== expId || rsp_data !== expData)
        begin fails++; $display("FAIL cont_rsp[%0d] got v=%b id=%b d=%h want v=1 id=%b d=%h", i, rsp_valid, rsp_id, rsp_data, expId, expData); end
    end
    @(negedge clk);
    drive0(1'b0, '0, '0, OpAdd);
    drive1(1'b0, '0, '0, OpAdd);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    drive0(1'b1, 32'd7, 32'd7, OpSub); rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_data !== 32'd0 || rsp_flags !== 3'b101)
      begin fails++; $display("FAIL bp_fill got d=%h f=%b want d=0 f=101", rsp_data, rsp_flags); end
    @(negedge clk);
    drive0(1'b0, '0, '0, OpAdd);
    drive1(1'b1, 32'd1, 32'd1, OpAdd);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL bp_req1_ready[%0d] got=%b want=0", i, req1_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd0 || rsp_flags !== 3'b101)
        begin fails++; $display("FAIL bp_hold[%0d] got v=%b id=%b d=%h f=%b want v=1 id=0 d=0 f=101", i, rsp_valid, rsp_id, rsp_data, rsp_flags); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b want=1", req1_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd2 || rsp_flags !== 3'b001)
      begin fails++; $display("FAIL bp_release_rsp got v=%b id=%b d=%h f=%b want v=1 id=1 d=2 f=001", rsp_valid, rsp_id, rsp_data, rsp_flags); end
    @(negedge clk); drive1(1'b0, '0, '0, OpAdd);
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive0(1'b1, 32'd1, W'(i), OpAdd);
      #1;
      checks++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, req0_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== W'(i + 1))
        begin fails++; $display("FAIL b2b_rsp[%0d] got v=%b d=%h want v=1 d=%h", i, rsp_valid, rsp_data, W'(i + 1)); end
    end
    @(negedge clk); drive0(1'b0, '0, '0, OpAdd);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    drive1(1'b1, 32'd3, 32'd4, OpAdd); rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive0(1'b1, 32'd30, 32'd0, OpAdd);
    drive1(1'b1, 32'd40, 32'd0, OpAdd);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd7)
      begin fails++; $display("FAIL arst_full got v=%b d=%h want v=1 d=7", rsp_valid, rsp_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL arst_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin fails++; $display("FAIL arst_ready_in_reset got=%b%b want=00", req0_ready, req1_ready); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin fails++; $display("FAIL arst_ready_after_release got=%b%b want=00", req0_ready, req1_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL arst_no_accept got=%b want=0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin fails++; $display("FAIL arst_first_grant got=%b%b want=10", req0_ready, req1_ready); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd30)
      begin fails++; $display("FAIL arst_first_rsp got v=%b id=%b d=%h want v=1 id=0 d=1e", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
    drive0(1'b0, '0, '0, OpAdd);
    drive1(1'b0, '0, '0, OpAdd);
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter that time-shares the single combinational ALU between the integer pipeline (requester 0) and the branch/address unit (requester 1). It owns the ALU operand and opcode inputs and grants at most one operation per cycle. It registers the ALU result and flags into a one-entry response buffer, tagged with the requester ID and held under backpressure. It sits between the decode/issue logic and the ALU instance.

## Interface
- WORD_LEN, 32, datapath width; matches the ALU operand width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WORD_LEN  requester 0 operands
- req0_op  in  4  requester 0 ALU opcode (ALUOp encoding)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a, alu_b  out  WORD_LEN  operands driven to ALU
- alu_op  out  4  opcode driven to ALU
- alu_out  in  WORD_LEN  ALU result
- alu_zero, alu_lt, alu_ge  in  1  ALU flags
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes response this cycle
- rsp_id  out  1  requester that issued the buffered result
- rsp_data  out  WORD_LEN  buffered result
- rsp_flags  out  3  {zero, lt, ge} captured with the result

## Operation
- State: response buffer (rsp_valid, rsp_id, rsp_data, rsp_flags) and priority pointer last_id (1 bit).
- can_accept = !rsp_valid || rsp_ready, so the buffer can refill in the same cycle it drains.
- Grant, combinational:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_id wins (round-robin).
- reqN_ready = can_accept && grant==N. A ready is never asserted without the matching valid.
- ALU drive:
  - Granted requester's a/b/op are muxed onto alu_a/alu_b/alu_op.
  - With no grant, drive 0/0/op 4'b0000, which gives a zero result. Opcode contents are not interpreted.
- Accept (reqN_valid && reqN_ready) at rising edge:
  - rsp_data <= alu_out, rsp_flags <= {alu_zero, alu_lt, alu_ge}, rsp_id <= N
  - rsp_valid <= 1, last_id <= N
- Drain without accept: rsp_valid <= 0. Data, id and flags hold their last values.
- Stall: while rsp_valid && !rsp_ready, both readies are 0 and the buffer and last_id hold.
- Requesters must keep valid and operands stable until ready. The arbiter does not check this.

## Timing
- Reset values:
  - rsp_valid 0, rsp_id 0, rsp_data 0, rsp_flags 3'b000
  - last_id 1, so requester 0 wins the first contention
  - req0_ready/req1_ready follow from these values: ready asserts on the first valid after reset
- Latency: an operation accepted in cycle T gives rsp_valid=1 in cycle T+1.
- Throughput: one operation per cycle while rsp_ready stays high.
- Simultaneous drain and accept in the same cycle: rsp_valid stays 1 and the new result replaces the old. No bubble.
- Both requesters valid continuously with rsp_ready=1: grants alternate 0,1,0,1...
- Reset mid-operation: the buffered result is discarded and rsp_valid drops immediately (asynchronous). The in-flight requester sees ready=0 until the first edge after reset deasserts.
- No combinational path from rsp_ready to alu_a/alu_b/alu_op. Only the readies depend on rsp_ready.

## Configuration
- ALU_ARB_RR_EN defined: round-robin contention as described above.
- ALU_ARB_RR_EN undefined:
  - Fixed priority: requester 0 always wins contention.
  - last_id is not implemented.
  - Requester 1 is granted only when req0_valid=0.
  - All other behaviour is identical.

## Test plan
- Reset then single op: req0 a=5, b=3, op=ADD, rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8, rsp_flags=3'b001.
- Contention round-robin (RR_EN): both valid for 4 cycles, rsp_ready=1 -> ids 0,1,0,1 on consecutive cycles. With RR_EN undefined -> ids 0,0,0,0 and req1_ready=0 throughout.
- Backpressure: fill buffer with SUB 7-7, hold rsp_ready=0 for 3 cycles with req1 valid -> rsp_data=0 and flags 3'b101 stable; req1_ready=0. Raise rsp_ready -> req1 accepted in that same cycle.
- Back-to-back drain and fill: rsp_ready=1 with continuous req0 stream of ADD 1+i for i=0..3 -> rsp_valid stays 1 and rsp_data goes 1,2,3,4 with no gap.
- Negative flag: req1 SUB a=2, b=5 -> rsp_data=32'hFFFFFFFD, rsp_flags=3'b010, rsp_id=1.
- Async reset mid-stall: buffer full and stalled; assert rst between clock edges -> rsp_valid=0 immediately; after release, the first contention grants requester 0.
